switch_debounce: RTL

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// Push-button debouncer: 2-flop synchronizer, four-state debounce FSM, press/release pulses, toggle and press counter.
// Optional long-press detector is compiled in only when SWITCH_DEBOUNCE_LONG_PRESS_EN is defined.
module switch_debounce #(
    parameter int DEBOUNCE_LIMIT   = 250000,
    parameter int LONG_PRESS_LIMIT = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch,
    output logic       o_Switch,
    output logic       o_Press,
    output logic       o_Release,
    output logic       o_Toggle,
    output logic [7:0] o_Press_Count,
    output logic       o_Long_Press
);

    // state     | meaning
    // IDLE_LOW  | debounced level 0, synchronized input agrees
    // WAIT_HIGH | input went high, counting stable cycles before accepting 1
    // IDLE_HIGH | debounced level 1, synchronized input agrees
    // WAIT_LOW  | input went low, counting stable cycles before accepting 0
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    if (DEBOUNCE_LIMIT < 1 || LONG_PRESS_LIMIT < 1) begin : g_bad_param
        $error("switch_debounce: DEBOUNCE_LIMIT and LONG_PRESS_LIMIT must be 1 or more");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic             sw_s;
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             switch_q,  switch_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             toggle_q,  toggle_d;
    logic [7:0]       count_q,   count_d;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
        end
    end

    assign sw_s = sync2_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            switch_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            switch_q  <= switch_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
            count_q   <= count_d;
        end
    end

    // A reversion of the input is tested before terminal count, so a bounce on the last cycle cancels acceptance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        switch_d  = switch_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        count_d   = count_q;
        case (state_q)
            IDLE_LOW: begin
                if (sw_s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sw_s) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE_HIGH;
                    switch_d = 1'b1;
                    press_d  = 1'b1;
                    toggle_d = ~toggle_q;
                    count_d  = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!sw_s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sw_s) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    switch_d  = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_Switch      = switch_q;
    assign o_Press       = press_q;
    assign o_Release     = release_q;
    assign o_Toggle      = toggle_q;
    assign o_Press_Count = count_q;

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_LIMIT);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Counter parks at LONG_PRESS_LIMIT so the pulse fires once per press.
    always_comb begin
        hold_d = '0;
        long_d = 1'b0;
        if (state_q == IDLE_HIGH && sw_s) begin
            hold_d = hold_q;
            if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + HOLD_W'(1);
                long_d = (hold_q == HOLD_LAST);
            end
        end
    end

    assign o_Long_Press = long_q;
`else
    assign o_Long_Press = 1'b0;
`endif

endmodule
